// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data widths, the canonical NOP and
// the fetch-buffer entry layout.
// Optional feature macro: FETCH_FAULT_EN adds a per-entry fault bit.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // One buffered fetch result: the PC it was fetched from and the word returned.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
`ifdef FETCH_FAULT_EN
    logic              fault;
`endif
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: synchronous write, registered head output, flush to empty.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         clear all entries and pointers this edge (wins over push/pop)
//   push, din     write din at the tail
//   pop           retire the head entry
//   dout, valid   registered head entry and its valid flag
//   full_c        buffer holds DEPTH entries
// The head register keeps its last value while empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned              DEPTH       = 2,
  parameter logic [FETCH_ENTRY_W-1:0] RESET_ENTRY = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [FETCH_ENTRY_W-1:0] din,
  output logic [FETCH_ENTRY_W-1:0] dout,
  output logic                     valid,
  output logic                     full_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FETCH_ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_nxt;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         count_nxt;
  logic [FETCH_ENTRY_W-1:0] dout_q;
  logic [FETCH_ENTRY_W-1:0] dout_nxt;
  logic                     valid_q;
  logic                     pop_ok;
  logic                     push_ok;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop & valid_q;
  assign push_ok = push & (~full_c | pop_ok);

  // Next head: the entry being written bypasses storage when it becomes the head.
  always_comb begin
    rd_ptr_nxt = rd_ptr_q + PTR_W'(pop_ok);
    count_nxt  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    dout_nxt   = dout_q;
    if (push_ok && (rd_ptr_nxt == wr_ptr_q)) begin
      dout_nxt = din;
    end else if (count_nxt != '0) begin
      dout_nxt = mem_q[rd_ptr_nxt];
    end
  end

  // Pointer, count and head register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      dout_q   <= RESET_ENTRY;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      valid_q  <= (count_nxt != '0);
      dout_q   <= dout_nxt;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational
// instruction memory and buffers {pc, instruction} toward decode.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pc_address      fetch address to inst_mem (the fetch PC register)
//   instruction     word from inst_mem for pc_address, same cycle
//   redirect_valid  flush the buffer and restart fetch at redirect_pc
//   redirect_pc     new fetch target (low two bits dropped)
//   out_valid/out_ready/out_pc/out_inst  head-of-buffer handshake to decode
//   out_fault       head entry faulted (only with FETCH_FAULT_EN)
// Optional feature macro: FETCH_FAULT_EN.
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned NUM_OF_INST = 1024,
  parameter int unsigned BUF_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_address,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef FETCH_FAULT_EN
  ,
  output logic        out_fault
`endif
);

`ifdef FETCH_FAULT_EN
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(NUM_OF_INST * 4);
  localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, inst: NOP_INST, fault: 1'b0};
`else
  localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, inst: NOP_INST};
`endif

  logic [XLEN-1:0] fetch_pc_q;
  logic            pop_c;
  logic            push_c;
  logic            full_c;
  fetch_entry_t    wr_entry;
  fetch_entry_t    rd_entry;

  assign pop_c  = out_valid & out_ready;
  assign push_c = ~redirect_valid & (~full_c | pop_c);

`ifdef FETCH_FAULT_EN
  logic mis_q;

  // Misaligned redirect target: flagged on the first entry fetched after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (redirect_valid) begin
      mis_q <= (redirect_pc[1:0] != 2'b00);
    end else if (push_c) begin
      mis_q <= 1'b0;
    end
  end

  assign wr_entry = '{pc:    fetch_pc_q,
                      inst:  instruction,
                      fault: mis_q | (fetch_pc_q >= MEM_BYTES)};
  assign out_fault = rd_entry.fault;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign wr_entry = '{pc: fetch_pc_q, inst: instruction};
`endif

  // Fetch PC: redirect wins, otherwise advance whenever a word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (push_c) begin
      fetch_pc_q <= fetch_pc_q + XLEN'(4);
    end
  end

  fetch_fifo #(
    .DEPTH       (BUF_DEPTH),
    .RESET_ENTRY (FETCH_ENTRY_W'(RST_ENTRY))
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_valid),
    .push   (push_c),
    .pop    (pop_c),
    .din    (wr_entry),
    .dout   (rd_entry),
    .valid  (out_valid),
    .full_c (full_c)
  );

  assign pc_address = fetch_pc_q;
  assign out_pc     = rd_entry.pc;
  assign out_inst   = rd_entry.inst;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit with an in-bench combinational instruction memory.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] pc_address;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef FETCH_FAULT_EN
  logic        out_fault;
`endif

  logic [31:0] mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  inst_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .NUM_OF_INST (1024),
    .BUF_DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_address     (pc_address),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
`ifdef FETCH_FAULT_EN
    ,
    .out_fault      (out_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    if (addr[31:2] < 30'(DEPTH)) return mem[addr[11:2]];
    return NOP;
  endfunction

  always_comb instruction = word_at(pc_address);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear with no clock edge.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_pc_address", pc_address, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, NOP);
`ifdef FETCH_FAULT_EN
    chk("rst_out_fault", 32'(out_fault), 32'h0);
`endif
    #1;
    rst = 1'b0;
  endtask

  // Directed vectors: inputs held for one cycle, outputs checked after the edge.
  typedef struct {
    logic        do_rst;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    logic        e_fault;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic dr, input logic rd, input logic [31:0] rp,
                              input logic rdy, input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei, input logic [31:0] ea, input logic ef);
    vec_t v;
    v.do_rst = dr; v.redir = rd; v.rpc = rp; v.ready = rdy;
    v.e_valid = ev; v.e_pc = ep; v.e_inst = ei; v.e_addr = ea; v.e_fault = ef;
    tbl.push_back(v);
  endfunction

  // Reference model: a queue of fetched entries plus the next fetch address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_last;
  logic [31:0] m_pc;
  logic        m_mis;

  function automatic void model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_mis  = 1'b0;
    m_last = '{pc: 32'h0, inst: NOP, fault: 1'b0};
  endfunction

  function automatic void model_edge(input logic rd, input logic [31:0] rp, input logic rdy);
    logic pop;
    logic push;
    ent_t e;
    pop  = (mq.size() != 0) && rdy;
    push = !rd && ((mq.size() < 2) || pop);
    if (rd) begin
      mq.delete();
      m_pc  = {rp[31:2], 2'b00};
      m_mis = (rp[1:0] != 2'b00);
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc    = m_pc;
        e.inst  = word_at(m_pc);
        e.fault = m_mis || (m_pc >= 32'(DEPTH * 4));
        mq.push_back(e);
        m_mis = 1'b0;
        m_pc  = m_pc + 32'd4;
      end
    end
    if (mq.size() != 0) m_last = mq[0];
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = (32'(i) << 20) | 32'h0000_0093;
    mem[0]    = 32'h0010_0033;
    mem[1]    = 32'h0020_0113;
    mem[2]    = 32'h0030_2193;
    mem[1023] = 32'h0040_4233;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    #3;
    chk("init_valid", 32'(out_valid), 32'h0);
    chk("init_pc_address", pc_address, 32'h0);
    chk("init_out_pc", out_pc, 32'h0);
    chk("init_out_inst", out_inst, NOP);
    #9;
    rst = 1'b0;
    chk("release_pc_address", pc_address, 32'h0);

    // Streaming from reset.
    add(0, 0, 0, 1, 1, 32'h0,    32'h0010_0033, 32'h4,    0);
    add(0, 0, 0, 1, 1, 32'h4,    32'h0020_0113, 32'h8,    0);
    add(0, 0, 0, 1, 1, 32'h8,    32'h0030_2193, 32'hC,    0);
    // Reset mid-stream, then stall five cycles until the buffer saturates.
    add(1, 0, 0, 0, 1, 32'h0,    32'h0010_0033, 32'h4,    0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 1, 32'h0,  32'h0010_0033, 32'h8,    0);
    add(0, 0, 0, 1, 1, 32'h4,    32'h0020_0113, 32'hC,    0);
    add(0, 0, 0, 1, 1, 32'h8,    32'h0030_2193, 32'h10,   0);
    add(0, 0, 0, 1, 1, 32'hC,    32'h0030_0093, 32'h14,   0);
    // Redirect while full to the last in-range word, then run off the end.
    add(0, 1, 32'hFFC, 0, 0, 32'hC, 32'h0030_0093, 32'hFFC, 0);
    add(0, 0, 0, 0, 1, 32'hFFC,  32'h0040_4233, 32'h1000, 0);
    add(0, 0, 0, 1, 1, 32'h1000, NOP,           32'h1004, 1);
    add(0, 0, 0, 1, 1, 32'h1004, NOP,           32'h1008, 1);
    // Redirect to a misaligned target on the same edge as a pop.
    add(0, 1, 32'h6, 1, 0, 32'h1004, NOP,       32'h4,    1);
    add(0, 0, 0, 0, 1, 32'h4,    32'h0020_0113, 32'h8,    1);
    add(0, 0, 0, 1, 1, 32'h8,    32'h0030_2193, 32'hC,    0);

    foreach (tbl[k]) begin
      if (tbl[k].do_rst) reset_pulse();
      redirect_valid = tbl[k].redir;
      redirect_pc    = tbl[k].rpc;
      out_ready      = tbl[k].ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'(tbl[k].e_valid));
      chk($sformatf("v%0d_pc_address", k), pc_address, tbl[k].e_addr);
      chk($sformatf("v%0d_out_pc", k), out_pc, tbl[k].e_pc);
      chk($sformatf("v%0d_out_inst", k), out_inst, tbl[k].e_inst);
`ifdef FETCH_FAULT_EN
      chk($sformatf("v%0d_out_fault", k), 32'(out_fault), 32'(tbl[k].e_fault));
`endif
    end

    // Randomized traffic against the queue model.
    reset_pulse();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        rd;
      logic [31:0] rp;
      logic        rdy;
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
        model_reset();
      end
      rd  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 65);
      case ($urandom_range(0, 3))
        0:       rp = 32'($urandom_range(0, 1100));
        1:       rp = 32'hFF0 + 32'($urandom_range(0, 32));
        2:       rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: rp = $urandom;
      endcase
      redirect_valid = rd;
      redirect_pc    = rp;
      out_ready      = rdy;
      @(posedge clk);
      model_edge(rd, rp, rdy);
      #1;
      chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd_pc_address", pc_address, m_pc);
      chk("rnd_out_pc", out_pc, m_last.pc);
      chk("rnd_out_inst", out_inst, m_last.inst);
`ifdef FETCH_FAULT_EN
      chk("rnd_out_fault", 32'(out_fault), 32'(m_last.fault));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
